i2c_pwm_multi: RTL and testbench

Multi-channel, parametrised successor to the single-channel I2C-controlled PWM generator. A 7-bit-addressed I2C slave exposes a small register file (per-channel duty, control, prescaler) with auto-incrementing index and read-back. It drives NUM_CH PWM outputs whose duty values are double-buffered and take effect only at period wrap, so outputs are glitch-free. It sits between the board I2C bus and the LED/motor driver pins.

---
 rtl/i2c_pwm_pkg.sv | 24 ++
 rtl/i2c_slave_if.sv | 163 ++++++++++++++++
 rtl/i2c_pwm_multi.sv | 99 +++++++++
 tb/tb_i2c_pwm_multi.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pwm_pkg.sv
// Shared types and register map for the I2C-controlled multi-channel PWM block.
package i2c_pwm_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } i2c_state_e;

  localparam logic [7:0] DUTY_BASE = 8'h00;
  localparam logic [7:0] CTRL_IDX  = 8'h10;
  localparam logic [7:0] PRESC_IDX = 8'h11;
  localparam logic [7:0] CTRL_RST  = 8'h01;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_INV_BIT = 1;

endpackage

// File: rtl/i2c_slave_if.sv
// I2C slave front end: bus synchroniser, START/STOP detection, protocol FSM,
// open-drain SDA drive and an auto-incrementing register index.
module i2c_slave_if
  import i2c_pwm_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       wr_en,
  output logic [7:0] wr_idx,
  output logic [7:0] wr_data,
  output logic [7:0] rd_idx,
  input  logic [7:0] rd_data
);

  logic [2:0] scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_c;

  i2c_state_e state;
  logic [3:0] bit_cnt;
  logic [7:0] shift, tx, idx;
  logic       sda_oe, ack_on, rw;

  // Synchronisers idle high so reset release never fakes a bus edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
    end else begin
      scl_s <= {scl_s[1:0], SCL};
      sda_s <= {sda_s[1:0], SDA};
    end
  end

  always_comb begin
    scl_rise  = scl_s[1] & ~scl_s[2];
    scl_fall  = ~scl_s[1] & scl_s[2];
    start_det = scl_s[1] & scl_s[2] & ~sda_s[1] & sda_s[2];
    stop_det  = scl_s[1] & scl_s[2] & sda_s[1] & ~sda_s[2];
    byte_c    = {shift[6:0], sda_s[1]};
  end

  assign SDA    = sda_oe ? 1'b0 : 1'bz;
  assign rd_idx = idx;

  // ACK states hold SDA low across one full bit: first fall drives, second fall releases
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shift   <= 8'h00;
      tx      <= 8'h00;
      idx     <= 8'h00;
      sda_oe  <= 1'b0;
      ack_on  <= 1'b0;
      rw      <= 1'b0;
      wr_en   <= 1'b0;
      wr_idx  <= 8'h00;
      wr_data <= 8'h00;
    end else begin
      wr_en <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR, REG, WDATA: begin
            if (scl_rise) begin
              shift   <= byte_c;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                case (state)
                  ADDR: begin
                    if (byte_c[7:1] == I2C_ADDR) begin
                      rw    <= byte_c[0];
                      state <= ADDR_ACK;
                    end else begin
                      state <= IDLE;
                    end
                  end
                  REG: begin
                    idx   <= byte_c;
                    state <= REG_ACK;
                  end
                  default: begin
                    wr_en   <= 1'b1;
                    wr_idx  <= idx;
                    wr_data <= byte_c;
                    idx     <= idx + 8'd1;
                    state   <= WDATA_ACK;
                  end
                endcase
              end
            end
          end
          ADDR_ACK, REG_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on <= 1'b1;
                sda_oe <= 1'b1;
              end else begin
                ack_on <= 1'b0;
                sda_oe <= 1'b0;
                if (state == ADDR_ACK && rw) begin
                  state  <= RDATA;
                  sda_oe <= ~rd_data[7];
                  tx     <= {rd_data[6:0], 1'b0};
                end else if (state == ADDR_ACK) begin
                  state <= REG;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                state   <= RDATA_ACK;
              end else begin
                sda_oe <= ~tx[7];
                tx     <= {tx[6:0], 1'b0};
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s[1]) begin
                state <= IDLE;
              end else begin
                idx    <= idx + 8'd1;
                ack_on <= 1'b1;
              end
            end else if (scl_fall && ack_on) begin
              ack_on <= 1'b0;
              state  <= RDATA;
              sda_oe <= ~rd_data[7];
              tx     <= {rd_data[6:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/i2c_pwm_multi.sv
// Register file and shared-counter PWM core behind an I2C slave; duties are
// double-buffered and only take effect at period wrap.
module i2c_pwm_multi
  import i2c_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PWM_W     = 8,
  parameter logic [6:0]  I2C_ADDR  = 7'h55,
  parameter logic [7:0]  PRESC_RST = 8'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCL,
  inout  wire               SDA,
  output logic [NUM_CH-1:0] pwm_out
);

  logic       wr_en;
  logic [7:0] wr_idx, wr_data, rd_idx, rd_data_c;

  logic [7:0]       shadow     [NUM_CH];
  logic [7:0]       shadow_nxt [NUM_CH];
  logic [PWM_W-1:0] active     [NUM_CH];
  logic [1:0]       ctrl;
  logic [7:0]       presc, presc_cnt;
  logic [PWM_W-1:0] cnt;
  logic             presc_wrap_c, period_wrap_c;

  i2c_slave_if #(.I2C_ADDR(I2C_ADDR)) u_slave (
    .clk     (clk),
    .rst     (rst),
    .SCL     (SCL),
    .SDA     (SDA),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data_c)
  );

  // Wide counters left-justify the 8-bit register; narrow ones keep its low bits
  function automatic logic [PWM_W-1:0] to_duty(input logic [7:0] r);
    logic [PWM_W+7:0] t;
    t = {r, {PWM_W{1'b0}}};
    if (PWM_W > 8) return t[PWM_W+7:8];
    else           return PWM_W'(r);
  endfunction

  always_comb begin
    presc_wrap_c  = (presc_cnt >= presc);
    period_wrap_c = presc_wrap_c && (cnt == {PWM_W{1'b1}});
    shadow_nxt    = shadow;
    if (wr_en) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_idx == DUTY_BASE + 8'(n)) shadow_nxt[n] = wr_data;
      end
    end
  end

  always_comb begin
    rd_data_c = 8'h00;
    for (int n = 0; n < NUM_CH; n++) begin
      if (rd_idx == DUTY_BASE + 8'(n)) rd_data_c = shadow[n];
    end
    if (rd_idx == CTRL_IDX)  rd_data_c = {6'b0, ctrl};
    if (rd_idx == PRESC_IDX) rd_data_c = presc;
  end

  // Wrap copies from shadow_nxt so a write on the wrap clock lands in this period
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        shadow[n] <= 8'h00;
        active[n] <= '0;
      end
      ctrl      <= CTRL_RST[1:0];
      presc     <= PRESC_RST;
      presc_cnt <= 8'h00;
      cnt       <= '0;
      pwm_out   <= '0;
    end else begin
      shadow <= shadow_nxt;
      if (wr_en && wr_idx == CTRL_IDX)  ctrl  <= wr_data[1:0];
      if (wr_en && wr_idx == PRESC_IDX) presc <= wr_data;
      if (presc_wrap_c) begin
        presc_cnt <= 8'h00;
        cnt       <= cnt + PWM_W'(1);
      end else begin
        presc_cnt <= presc_cnt + 8'd1;
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (period_wrap_c) active[n] <= to_duty(shadow_nxt[n]);
        pwm_out[n] <= ctrl[CTRL_EN_BIT] ? ((cnt < active[n]) ^ ctrl[CTRL_INV_BIT])
                                        : ctrl[CTRL_INV_BIT];
      end
    end
  end

endmodule

// File: tb/tb_i2c_pwm_multi.sv
// Scoreboard bench for i2c_pwm_multi: bit-banged I2C master, expected values
// queued by stimulus, compared by a monitor as observations arrive.
module tb_i2c_pwm_multi;

  localparam int unsigned NUM_CH = 4;
  localparam int Q = 8;

  typedef struct {
    string name;
    int    val;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_m = 1'b1;
  logic m_low = 1'b0;
  logic watch = 1'b0;
  int   bad_drv = 0;
  wire  SDA;
  logic [NUM_CH-1:0] pwm_out;

  item_t exp_q[$];
  item_t act_q[$];
  int checks = 0;
  int errors = 0;

  pullup (SDA);
  assign SDA = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_pwm_multi #(
    .NUM_CH(NUM_CH), .PWM_W(8), .I2C_ADDR(7'h55), .PRESC_RST(8'd0)
  ) dut (
    .clk(clk), .rst(rst), .SCL(scl_m), .SDA(SDA), .pwm_out(pwm_out)
  );

  // Any low on SDA that the master is not causing comes from the DUT
  always @(negedge clk) begin
    if (watch && SDA === 1'b0 && !m_low) bad_drv++;
  end

  // Monitor: pops one expectation per observation
  initial begin
    item_t a;
    item_t e;
    forever begin
      @(negedge clk);
      while (act_q.size() > 0) begin
        a = act_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s: got %0d, no value was expected", a.name, a.val);
        end else begin
          e = exp_q.pop_front();
          if (a.val != e.val || a.name != e.name) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (expected item %s)",
                     a.name, a.val, e.val, e.name);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic exp_push(input string nm, input int v);
    item_t it;
    it.name = nm;
    it.val  = v;
    exp_q.push_back(it);
  endtask

  task automatic act_push(input string nm, input int v);
    item_t it;
    it.name = nm;
    it.val  = v;
    act_q.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wbit(input logic b);
    m_low = ~b;
    tick(Q); scl_m = 1'b1;
    tick(2*Q); scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic rbit(output logic b);
    m_low = 1'b0;
    tick(Q); scl_m = 1'b1;
    tick(Q);
    @(negedge clk);
    b = SDA;
    tick(Q); scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start;
    m_low = 1'b0;
    tick(Q); scl_m = 1'b1;
    tick(Q); m_low = 1'b1;
    tick(Q); scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop;
    m_low = 1'b1;
    tick(Q); scl_m = 1'b1;
    tick(Q); m_low = 1'b0;
    tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, input string nm);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    act_push(nm, int'(a));
  endtask

  task automatic rbyte(input string nm, input logic ack);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    act_push(nm, int'(d));
    wbit(~ack);
  endtask

  task automatic wr_txn(input logic [7:0] idx, input int n,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
    logic [7:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    i2c_start;
    exp_push("ack_addr", 0); wbyte(8'hAA, "ack_addr");
    exp_push("ack_idx", 0);  wbyte(idx, "ack_idx");
    for (int i = 0; i < n; i++) begin
      exp_push("ack_data", 0);
      wbyte(d[i], "ack_data");
    end
    i2c_stop;
  endtask

  // Sets index, repeated START, reads n bytes (ACK all but last), then one
  // extra clock with SDA released to show the slave has gone idle
  task automatic rd_txn(input logic [7:0] idx, input int n,
                        input logic [7:0] e0, input logic [7:0] e1);
    logic b;
    i2c_start;
    exp_push("ack_addr", 0);  wbyte(8'hAA, "ack_addr");
    exp_push("ack_idx", 0);   wbyte(idx, "ack_idx");
    i2c_start;
    exp_push("ack_raddr", 0); wbyte(8'hAB, "ack_raddr");
    exp_push("rd_byte0", int'(e0)); rbyte("rd_byte0", n > 1);
    if (n > 1) begin
      exp_push("rd_byte1", int'(e1)); rbyte("rd_byte1", 1'b0);
    end
    exp_push("idle_after_nack", 1);
    rbit(b);
    act_push("idle_after_nack", int'(b));
    i2c_stop;
  endtask

  task automatic measure(input int win, input int e0, input int e1,
                         input int e2, input int e3);
    int e [NUM_CH];
    int c [NUM_CH];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int n = 0; n < NUM_CH; n++) begin
      c[n] = 0;
      exp_push($sformatf("pwm_ch%0d", n), e[n]);
    end
    repeat (win) begin
      @(negedge clk);
      for (int n = 0; n < NUM_CH; n++) if (pwm_out[n]) c[n]++;
    end
    for (int n = 0; n < NUM_CH; n++) act_push($sformatf("pwm_ch%0d", n), c[n]);
  endtask

  initial begin
    rst = 1'b0;
    tick(5);
    exp_push("rst_pwm", 0);
    exp_push("rst_sda", 1);
    @(negedge clk);
    act_push("rst_pwm", int'(pwm_out));
    act_push("rst_sda", int'(SDA));
    rst = 1'b1;
    tick(10);

    // CTRL then PRESC read back across a repeated START
    rd_txn(8'h10, 2, 8'h01, 8'h00);

    wr_txn(8'h00, 1, 8'h80, 8'h00, 8'h00, 8'h00);
    tick(600);
    measure(256, 128, 0, 0, 0);

    wr_txn(8'h00, 4, 8'h40, 8'hC0, 8'h00, 8'hFF);
    tick(600);
    measure(256, 64, 192, 0, 255);

    // Channel 3 then unmapped index 0x04
    rd_txn(8'h03, 2, 8'hFF, 8'h00);

    watch = 1'b1;
    i2c_start;
    exp_push("nack_bad_addr", 1); wbyte(8'hA8, "nack_bad_addr");
    exp_push("nack_bad_d0", 1);   wbyte(8'h00, "nack_bad_d0");
    exp_push("nack_bad_d1", 1);   wbyte(8'h77, "nack_bad_d1");
    i2c_stop;
    watch = 1'b0;
    exp_push("bad_addr_drive", 0);
    act_push("bad_addr_drive", bad_drv);
    tick(20);
    measure(256, 64, 192, 0, 255);

    wr_txn(8'h10, 1, 8'h03, 8'h00, 8'h00, 8'h00);
    tick(20);
    measure(256, 192, 64, 256, 1);

    wr_txn(8'h10, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    tick(20);
    measure(256, 0, 0, 0, 0);

    wr_txn(8'h10, 1, 8'h01, 8'h00, 8'h00, 8'h00);
    wr_txn(8'h11, 1, 8'h01, 8'h00, 8'h00, 8'h00);
    tick(600);
    measure(512, 128, 384, 0, 510);

    // Reset in the middle of a data byte
    i2c_start;
    exp_push("ack_addr", 0); wbyte(8'hAA, "ack_addr");
    exp_push("ack_idx", 0);  wbyte(8'h00, "ack_idx");
    for (int i = 0; i < 4; i++) wbit(1'b1);
    rst = 1'b0;
    tick(1);
    exp_push("midrst_sda", 1);
    exp_push("midrst_pwm", 0);
    @(negedge clk);
    act_push("midrst_sda", int'(SDA));
    act_push("midrst_pwm", int'(pwm_out));
    tick(3);
    m_low = 1'b0;
    scl_m = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(20);

    rd_txn(8'h00, 1, 8'h00, 8'h00);
    wr_txn(8'h00, 1, 8'h80, 8'h00, 8'h00, 8'h00);
    rd_txn(8'h00, 1, 8'h80, 8'h00);
    tick(600);
    measure(256, 128, 0, 0, 0);

    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
